// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: N:1 CBus arbiter with a single-outstanding-transaction lock.
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   resetn  - asynchronous active-low reset
//   ireqs   - NUM_INPUTS upstream requests (cbus_req_t)
//   iresps  - NUM_INPUTS upstream responses; only the granted entry is live
//   oreq    - request forwarded to the downstream memory bus
//   oresp   - response from the downstream memory bus
//
// Configuration macro:
//   CBUS_ARB_ROUND_ROBIN_EN - defined: round-robin search starting after the
//                             last winner; undefined: fixed priority, lowest
//                             valid index wins.
//
// oreq/iresps are combinational views of the granted path so bursts forward
// with zero added latency once the grant is held.

package cbus_pkg;
  localparam int unsigned CBUS_AW = 32;
  localparam int unsigned CBUS_DW = 32;
  localparam int unsigned CBUS_SW = CBUS_DW / 8;
  localparam int unsigned CBUS_LW = 8;

  typedef struct packed {
    logic               valid;
    logic               is_write;
    logic [1:0]         size;
    logic [CBUS_AW-1:0] addr;
    logic [CBUS_SW-1:0] strobe;
    logic [CBUS_DW-1:0] data;
    logic [CBUS_LW-1:0] len;
  } cbus_req_t;

  typedef struct packed {
    logic               ready;
    logic               last;
    logic [CBUS_DW-1:0] data;
  } cbus_resp_t;
endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  cbus_req_t  [NUM_INPUTS-1:0] ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0] iresps,
  output cbus_req_t                   oreq,
  input  cbus_resp_t                  oresp
);

  localparam int unsigned IDX_W = $clog2(NUM_INPUTS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic               done;

  assign done = oresp.ready & oresp.last;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]   last_q, last_d;

  // Round-robin pick: first valid index after the last winner, wrapping.
  always_comb begin
    int unsigned cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
      cand = (32'(last_q) + k) % NUM_INPUTS;
      if (!sel_found && ireqs[IDX_W'(cand)].valid) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end
`else
  // Fixed-priority pick: lowest valid index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (!sel_found && ireqs[IDX_W'(k)].valid) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(k);
      end
    end
  end
`endif

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    oreq    = '0;
    iresps  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          grant_d = sel_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Grant is frozen until ready&last, even if the requester drops valid.
        oreq            = ireqs[grant_q];
        iresps[grant_q] = oresp;
        if (done) begin
          state_d = ST_IDLE;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
          last_d  = grant_q;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, grant and last-winner registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
      last_q  <= IDX_W'(NUM_INPUTS - 1);
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Scoreboarded directed bench for cbus_rr_arbiter (2-input main instance,
// 4-input instance for the wrap-around case).
module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;

  cbus_req_t  [1:0] ireqs;
  cbus_resp_t [1:0] iresps;
  cbus_req_t        oreq;
  cbus_resp_t       oresp;

  cbus_req_t  [3:0] ireqs1;
  cbus_resp_t [3:0] iresps1;
  cbus_req_t        oreq1;
  cbus_resp_t       oresp1;

  cbus_rr_arbiter #(.NUM_INPUTS(2)) dut (
    .clk(clk), .resetn(resetn), .ireqs(ireqs), .iresps(iresps),
    .oreq(oreq), .oresp(oresp)
  );

  cbus_rr_arbiter #(.NUM_INPUTS(4)) dut4 (
    .clk(clk), .resetn(resetn), .ireqs(ireqs1), .iresps(iresps1),
    .oreq(oreq1), .oresp(oresp1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        idx;
    cbus_req_t req;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic prev_v = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  function automatic cbus_req_t mk_req(input logic [31:0] addr, input logic [7:0] len);
    cbus_req_t r;
    r.valid    = 1'b1;
    r.is_write = addr[12];
    r.size     = 2'd2;
    r.addr     = addr;
    r.strobe   = 4'hF;
    r.data     = addr ^ 32'hA5A5_0000;
    r.len      = len;
    return r;
  endfunction

  function automatic cbus_resp_t mk_resp(input logic rdy, input logic lst, input logic [31:0] d);
    cbus_resp_t p;
    p.ready = rdy;
    p.last  = lst;
    p.data  = d;
    return p;
  endfunction

  task automatic push(input int idx, input cbus_req_t r);
    exp_t e;
    e.idx = idx;
    e.req = r;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation at each new grant, checks hold and responses.
  always @(negedge clk) begin
    if (resetn && oreq.valid) begin
      if (!prev_v) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL sb_unexpected_grant: got addr %h expected no grant", oreq.addr);
        end else begin
          cur = exp_q.pop_front();
          chk("sb_grant", 128'(oreq), 128'(cur.req));
        end
      end else begin
        chk("sb_hold", 128'(oreq), 128'(cur.req));
      end
      if (oresp.ready) begin
        chk("sb_resp", 128'(iresps[cur.idx]), 128'(oresp));
        chk("sb_other_zero", 128'(iresps[1-cur.idx]), 128'(0));
      end
    end
    prev_v = resetn & oreq.valid;
  end

  cbus_req_t ra, rb;
  logic [7:0] pat;

  initial begin
    resetn = 1'b0;
    ireqs  = '0;
    oresp  = '0;
    ireqs1 = '0;
    oresp1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_oreq", 128'(oreq), 128'(0));
    chk("rst_iresps", 128'(iresps), 128'(0));
    chk("rst_oreq4", 128'(oreq1), 128'(0));
    tick();
    resetn = 1'b1;
    tick();

    // Single request on index 1
    ra = mk_req(32'h0000_1000, 8'd0);
    ireqs[1] = ra;
    push(1, ra);
    @(negedge clk); chk("single_c0_idle", 128'(oreq.valid), 128'(0));
    tick();
    @(negedge clk); chk("single_c1_oreq", 128'(oreq), 128'(ra));
    tick();
    tick(); oresp = mk_resp(1'b1, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("single_c3_rdata", 128'(iresps[1].data), 128'(32'hDEAD_BEEF));
    chk("single_c3_other", 128'(iresps[0]), 128'(0));
    tick(); ireqs = '0; oresp = '0;
    @(negedge clk); chk("single_c4_idle", 128'(oreq.valid), 128'(0));
    tick();

    // Burst lock: 4-beat burst on 0, requester 1 arrives mid-burst
    ra = mk_req(32'h0000_4000, 8'd3);
    rb = mk_req(32'h0000_5000, 8'd0);
    ireqs[0] = ra; push(0, ra);
    tick();                                                  // c1
    tick(); oresp = mk_resp(1'b1, 1'b0, 32'h0000_00A0);       // c2
    ireqs[1] = rb; push(1, rb);
    tick(); oresp = '0;                                      // c3
    tick(); oresp = mk_resp(1'b1, 1'b0, 32'h0000_00A1);       // c4
    tick(); oresp = mk_resp(1'b1, 1'b0, 32'h0000_00A2);       // c5
    tick(); oresp = '0;                                      // c6
    tick(); oresp = mk_resp(1'b1, 1'b1, 32'h0000_00A3);       // c7
    @(negedge clk); chk("burst_c7_locked", 128'(oreq), 128'(ra));
    tick(); ireqs[0] = '0; oresp = '0;                       // c8
    @(negedge clk); chk("burst_c8_gap", 128'(oreq.valid), 128'(0));
    tick();                                                  // c9
    @(negedge clk); chk("burst_c9_next", 128'(oreq), 128'(rb));
    tick(); oresp = mk_resp(1'b1, 1'b1, 32'h0000_00B0);       // c10
    tick(); ireqs = '0; oresp = '0;
    tick();

    // Contention from reset, single-beat transactions
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    ra = mk_req(32'h0000_2000, 8'd0);
    rb = mk_req(32'h0000_3000, 8'd0);
    ireqs[0] = ra;
    ireqs[1] = rb;
    oresp = mk_resp(1'b1, 1'b1, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      if (RR && (i % 2 == 1)) push(1, rb);
      else push(0, ra);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat[i] = oreq.valid;
      tick();
    end
    ireqs = '0; oresp = '0;
    chk("contend_valid_pattern", 128'(pat), 128'(8'b1010_1010));
    tick();

    // Reset in the middle of a burst
    ra = mk_req(32'h0000_6000, 8'd7);
    ireqs[1] = ra; push(1, ra);
    tick();                                                  // c1 granted
    tick(); oresp = mk_resp(1'b1, 1'b0, 32'h0000_00C0);       // c2
    tick(); oresp = mk_resp(1'b1, 1'b0, 32'h0000_00C1);       // c3
    tick(); oresp = mk_resp(1'b1, 1'b0, 32'h0000_00C2);       // c4
    #2 resetn = 1'b0;
    #1;
    chk("rst_mid_oreq", 128'(oreq), 128'(0));
    chk("rst_mid_iresps", 128'(iresps), 128'(0));
    tick();
    rb = mk_req(32'h0000_7000, 8'd0);
    ireqs[0] = rb;
    oresp = '0;
    resetn = 1'b1;
    push(0, rb);
    @(negedge clk); chk("rst_after_idle", 128'(oreq.valid), 128'(0));
    tick();
    @(negedge clk); chk("rst_after_grant0", 128'(oreq), 128'(rb));
    tick(); oresp = mk_resp(1'b1, 1'b1, 32'h0000_00D0);
    tick(); ireqs = '0; oresp = '0;
    tick();

    // Wrap-around on the 4-input instance
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    ra = mk_req(32'h0000_8100, 8'd0);
    rb = mk_req(32'h0000_8300, 8'd0);
    ireqs1[1] = ra;
    ireqs1[3] = rb;
    @(negedge clk); chk("wrap_idle", 128'(oreq1.valid), 128'(0));
    tick();
    @(negedge clk); chk("wrap_first_grant", 128'(oreq1), 128'(ra));
    tick(); oresp1 = mk_resp(1'b1, 1'b1, 32'h0000_00E1);
    @(negedge clk);
    chk("wrap_resp1", 128'(iresps1[1]), 128'(mk_resp(1'b1, 1'b1, 32'h0000_00E1)));
    chk("wrap_resp3_zero", 128'(iresps1[3]), 128'(0));
    tick(); oresp1 = '0;
    @(negedge clk); chk("wrap_gap", 128'(oreq1.valid), 128'(0));
    tick();
    @(negedge clk); chk("wrap_second_grant", 128'(oreq1), RR ? 128'(rb) : 128'(ra));
    ireqs1 = '0;
    tick();
    tick();

    chk("sb_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
